// File: rtl/p_hardisc.sv
// Shared fetch-side types: aligner state and the RVC opcode marker.
package p_hardisc;

  typedef enum logic {
    AL_EMPTY = 1'b0,
    AL_HALF  = 1'b1
  } al_state_e;

  // Bits [1:0] of a halfword equal to this mark the low half of a 32-bit instruction.
  localparam logic [1:0] RVC_OPC_FULL = 2'b11;

endpackage

// File: rtl/al_halfbuf.sv
// One-halfword carry buffer: leftover upper halfword with its address and error flag.
module al_halfbuf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [15:0]       data_i,
  input  logic [ADDR_W-1:1] addr_i,
  input  logic              err_i,
  output logic [15:0]       hb_o,
  output logic [ADDR_W-1:1] hb_addr_o,
  output logic              hb_err_o
);

  logic [15:0]       hb_q;
  logic [ADDR_W-1:1] hb_addr_q;
  logic              hb_err_q;

  // Clear wins over load so a redirect always drops the carried halfword.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hb_q      <= '0;
      hb_addr_q <= '0;
      hb_err_q  <= 1'b0;
    end else if (clear_i) begin
      hb_q      <= '0;
      hb_addr_q <= '0;
      hb_err_q  <= 1'b0;
    end else if (load_i) begin
      hb_q      <= data_i;
      hb_addr_q <= addr_i;
      hb_err_q  <= err_i;
    end
  end

  assign hb_o      = hb_q;
  assign hb_addr_o = hb_addr_q;
  assign hb_err_o  = hb_err_q;

endmodule

// File: rtl/rvc_aligner.sv
// Splits 32-bit fetch words into aligned 16-bit RVC or 32-bit instructions, one per handshake.
module rvc_aligner
  import p_hardisc::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter bit          RVC_EN = 1'b1
) (
  input  logic              s_clk_i,
  input  logic              s_reset_i,
  input  logic              s_flush_i,
  input  logic [ADDR_W-1:0] s_flush_addr_i,
  input  logic              s_fetch_valid_i,
  input  logic [31:0]       s_fetch_data_i,
  input  logic [ADDR_W-1:0] s_fetch_addr_i,
  input  logic              s_fetch_err_i,
  output logic              s_fetch_ready_o,
  output logic              s_instr_valid_o,
  output logic [31:0]       s_instr_o,
  output logic [ADDR_W-1:0] s_instr_addr_o,
  output logic              s_instr_rvc_o,
  output logic              s_instr_err_o,
  input  logic              s_instr_ready_i
);

  al_state_e state_q, state_d;
  logic      skip_q, skip_d;

  logic              hb_load, hb_clear;
  logic [15:0]       hb;
  logic [ADDR_W-1:1] hb_addr;
  logic              hb_err;

  logic [15:0]       lo, hi;
  logic [ADDR_W-1:1] hi_addr;
  logic              lo_rvc, hi_rvc, hb_rvc;
  logic              accept, consume;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_fetch_addr_i[1:0], s_flush_addr_i[ADDR_W-1:2], s_flush_addr_i[0]};

  assign lo      = s_fetch_data_i[15:0];
  assign hi      = s_fetch_data_i[31:16];
  assign hi_addr = {s_fetch_addr_i[ADDR_W-1:2], 1'b1};
  assign lo_rvc  = RVC_EN && (lo[1:0] != RVC_OPC_FULL);
  assign hi_rvc  = RVC_EN && (hi[1:0] != RVC_OPC_FULL);
  assign hb_rvc  = RVC_EN && (hb[1:0] != RVC_OPC_FULL);

  assign accept  = s_instr_valid_o & s_instr_ready_i;
  assign consume = s_fetch_valid_i & s_fetch_ready_o;

  al_halfbuf #(
    .ADDR_W (ADDR_W)
  ) u_halfbuf (
    .clk_i     (s_clk_i),
    .rst_i     (s_reset_i),
    .load_i    (hb_load),
    .clear_i   (hb_clear),
    .data_i    (hi),
    .addr_i    (hi_addr),
    .err_i     (s_fetch_err_i),
    .hb_o      (hb),
    .hb_addr_o (hb_addr),
    .hb_err_o  (hb_err)
  );

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state_q <= AL_EMPTY;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    hb_load  = 1'b0;
    hb_clear = 1'b0;
    if (s_flush_i) begin
      state_d  = AL_EMPTY;
      skip_d   = RVC_EN && s_flush_addr_i[1];
      hb_clear = 1'b1;
    end else begin
      unique case (state_q)
        AL_EMPTY: begin
          if (!skip_q) begin
            if (accept && lo_rvc) begin
              hb_load = 1'b1;
              state_d = AL_HALF;
            end
          end else if (hi_rvc) begin
            if (accept) skip_d = 1'b0;
          end else if (consume) begin
            // Upper half starts a 32-bit instruction: park it and wait for its second half.
            hb_load = 1'b1;
            skip_d  = 1'b0;
            state_d = AL_HALF;
          end
        end
        AL_HALF: begin
          if (hb_rvc) begin
            if (accept) state_d = AL_EMPTY;
          end else if (accept) begin
            hb_load = 1'b1;
          end
        end
        default: state_d = AL_EMPTY;
      endcase
    end
  end

  always_comb begin
    s_instr_valid_o = 1'b0;
    s_fetch_ready_o = 1'b0;
    s_instr_o       = '0;
    s_instr_addr_o  = '0;
    s_instr_rvc_o   = 1'b0;
    s_instr_err_o   = 1'b0;
    if (!s_reset_i && !s_flush_i) begin
      unique case (state_q)
        AL_EMPTY: begin
          if (!skip_q) begin
            s_instr_valid_o = s_fetch_valid_i;
            s_fetch_ready_o = s_instr_ready_i;
            s_instr_addr_o  = s_fetch_addr_i;
            s_instr_err_o   = s_fetch_err_i;
            s_instr_rvc_o   = lo_rvc;
            s_instr_o       = lo_rvc ? {16'h0000, lo} : s_fetch_data_i;
          end else if (hi_rvc) begin
            s_instr_valid_o = s_fetch_valid_i;
            s_fetch_ready_o = s_instr_ready_i;
            s_instr_addr_o  = {hi_addr, 1'b0};
            s_instr_err_o   = s_fetch_err_i;
            s_instr_rvc_o   = 1'b1;
            s_instr_o       = {16'h0000, hi};
          end else begin
            s_fetch_ready_o = 1'b1;
          end
        end
        AL_HALF: begin
          s_instr_addr_o = {hb_addr, 1'b0};
          if (hb_rvc) begin
            s_instr_valid_o = 1'b1;
            s_instr_rvc_o   = 1'b1;
            s_instr_err_o   = hb_err;
            s_instr_o       = {16'h0000, hb};
          end else begin
            s_instr_valid_o = s_fetch_valid_i;
            s_fetch_ready_o = s_instr_ready_i;
            s_instr_err_o   = hb_err | s_fetch_err_i;
            s_instr_o       = {lo, hb};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_aligner.sv
// Scoreboard bench: a halfword-stream parser predicts the instruction sequence of each segment.
module tb_rvc_aligner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush, fv, ferr, fready, ivalid, irvc, ierr, iready;
  logic [31:0] flush_addr, fdata, faddr, instr, iaddr;

  logic        z_flush, z_fv, z_ferr, z_fready, z_ivalid, z_irvc, z_ierr, z_iready;
  logic [31:0] z_flush_addr, z_fdata, z_faddr, z_instr, z_iaddr;

  rvc_aligner #(.ADDR_W(32), .RVC_EN(1'b1)) u_dut (
    .s_clk_i         (clk),
    .s_reset_i       (rst),
    .s_flush_i       (flush),
    .s_flush_addr_i  (flush_addr),
    .s_fetch_valid_i (fv),
    .s_fetch_data_i  (fdata),
    .s_fetch_addr_i  (faddr),
    .s_fetch_err_i   (ferr),
    .s_fetch_ready_o (fready),
    .s_instr_valid_o (ivalid),
    .s_instr_o       (instr),
    .s_instr_addr_o  (iaddr),
    .s_instr_rvc_o   (irvc),
    .s_instr_err_o   (ierr),
    .s_instr_ready_i (iready)
  );

  rvc_aligner #(.ADDR_W(32), .RVC_EN(1'b0)) u_dut_norvc (
    .s_clk_i         (clk),
    .s_reset_i       (rst),
    .s_flush_i       (z_flush),
    .s_flush_addr_i  (z_flush_addr),
    .s_fetch_valid_i (z_fv),
    .s_fetch_data_i  (z_fdata),
    .s_fetch_addr_i  (z_faddr),
    .s_fetch_err_i   (z_ferr),
    .s_fetch_ready_o (z_fready),
    .s_instr_valid_o (z_ivalid),
    .s_instr_o       (z_instr),
    .s_instr_addr_o  (z_iaddr),
    .s_instr_rvc_o   (z_irvc),
    .s_instr_err_o   (z_ierr),
    .s_instr_ready_i (z_iready)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        rvc;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wq_d[$], wq_a[$];
  logic        wq_e[$];
  logic [31:0] seg_w[$];
  logic        seg_e[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hw_rvc(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  // Walk the halfword stream from the start address; a trailing lone low half is never emitted.
  task automatic model_seg(input logic [31:0] start);
    logic [15:0] hw[$];
    logic [31:0] ha[$];
    logic        he[$];
    logic [31:0] base;
    exp_t        e;
    int          i;
    base = {start[31:2], 2'b00};
    for (int k = 0; k < seg_w.size(); k++) begin
      hw.push_back(seg_w[k][15:0]);
      ha.push_back(base + 32'(4 * k));
      he.push_back(seg_e[k]);
      hw.push_back(seg_w[k][31:16]);
      ha.push_back(base + 32'(4 * k + 2));
      he.push_back(seg_e[k]);
    end
    i = start[1] ? 1 : 0;
    while (i < hw.size()) begin
      if (hw_rvc(hw[i])) begin
        e.instr = {16'h0000, hw[i]};
        e.addr  = ha[i];
        e.rvc   = 1'b1;
        e.err   = he[i];
        exp_q.push_back(e);
        i += 1;
      end else if (i + 1 < hw.size()) begin
        e.instr = {hw[i + 1], hw[i]};
        e.addr  = ha[i];
        e.rvc   = 1'b0;
        e.err   = he[i] | he[i + 1];
        exp_q.push_back(e);
        i += 2;
      end else begin
        break;
      end
    end
  endtask

  task automatic feed();
    int cyc;
    bit fired;
    cyc = 0;
    while ((wq_d.size() > 0 || exp_q.size() > 0) && cyc < 500) begin
      if (!fv && wq_d.size() > 0 && $urandom_range(3) != 0) begin
        fv    = 1'b1;
        fdata = wq_d[0];
        faddr = wq_a[0];
        ferr  = wq_e[0];
      end
      iready = ($urandom_range(3) != 0);
      @(negedge clk);
      fired = fv & fready;
      @(posedge clk);
      #1;
      cyc++;
      if (fired) begin
        void'(wq_d.pop_front());
        void'(wq_a.pop_front());
        void'(wq_e.pop_front());
        fv = 1'b0;
      end
    end
    if (cyc >= 500) begin
      checks++;
      errors++;
      $display("FAIL seg_timeout: words left %0d, instrs left %0d, required 0 and 0",
               wq_d.size(), exp_q.size());
      wq_d.delete();
      wq_a.delete();
      wq_e.delete();
      exp_q.delete();
    end
    fv = 1'b0;
  endtask

  task automatic run_seg(input logic [31:0] start, input bit do_flush);
    logic [31:0] base;
    base = {start[31:2], 2'b00};
    if (do_flush) begin
      // Junk word offered during the flush must be neither consumed nor decoded.
      flush      = 1'b1;
      flush_addr = start;
      fv         = 1'b1;
      fdata      = 32'h0000_0001;
      faddr      = 32'h0000_0ff0;
      ferr       = 1'b0;
      iready     = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      fv    = 1'b0;
    end
    model_seg(start);
    for (int k = 0; k < seg_w.size(); k++) begin
      wq_d.push_back(seg_w[k]);
      wq_a.push_back(base + 32'(4 * k));
      wq_e.push_back(seg_e[k]);
    end
    seg_w.delete();
    seg_e.delete();
    feed();
  endtask

  task automatic add_word(input logic [31:0] w, input logic e);
    seg_w.push_back(w);
    seg_e.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    bit          prev_pend;
    logic [65:0] prev_out;
    prev_pend = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pend = 1'b0;
        continue;
      end
      if (flush) begin
        chk("flush_valid", 80'(ivalid), 80'(0));
        chk("flush_ready", 80'(fready), 80'(0));
        prev_pend = 1'b0;
        continue;
      end
      if (prev_pend) chk("stable", 80'({ivalid, instr, iaddr, irvc, ierr}), 80'({1'b1, prev_out}));
      if (ivalid && iready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got %h @%h rvc=%0b, required none", instr, iaddr, irvc);
        end else begin
          e = exp_q.pop_front();
          chk("instr", 80'({instr, iaddr, irvc, ierr}), 80'({e.instr, e.addr, e.rvc, e.err}));
        end
      end
      prev_pend = ivalid && !iready;
      prev_out  = {instr, iaddr, irvc, ierr};
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] start;
    logic [31:0] hwa, hwb;
    int          n;
    flush = 1'b0; flush_addr = '0; fv = 1'b1; fdata = 32'h0000_0001; faddr = '0;
    ferr = 1'b1; iready = 1'b1;
    z_flush = 1'b0; z_flush_addr = '0; z_fv = 1'b0; z_fdata = '0; z_faddr = '0;
    z_ferr = 1'b0; z_iready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 80'(ivalid), 80'(0));
    chk("reset_fready", 80'(fready), 80'(0));
    chk("reset_instr", 80'({instr, iaddr, irvc, ierr}), 80'(0));
    rst = 1'b0;
    fv  = 1'b0;
    ferr = 1'b0;
    iready = 1'b0;
    @(posedge clk);
    #1;

    // RVC_EN=0 instance: every word is a whole 32-bit instruction, odd flush targets ignored.
    z_fv = 1'b1; z_fdata = 32'h0001_0001; z_faddr = 32'h0000_0700; z_iready = 1'b1;
    #1;
    chk("norvc_word", 80'({z_ivalid, z_fready, z_instr, z_iaddr, z_irvc}),
        80'({1'b1, 1'b1, 32'h0001_0001, 32'h0000_0700, 1'b0}));
    @(posedge clk);
    #1;
    z_flush = 1'b1; z_flush_addr = 32'h0000_0702; z_fv = 1'b0;
    #1;
    chk("norvc_flush_valid", 80'({z_ivalid, z_fready}), 80'(0));
    @(posedge clk);
    #1;
    z_flush = 1'b0; z_fv = 1'b1; z_fdata = 32'h0002_0001; z_faddr = 32'h0000_0704; z_ferr = 1'b1;
    #1;
    chk("norvc_after_flush", 80'({z_ivalid, z_instr, z_iaddr, z_irvc, z_ierr}),
        80'({1'b1, 32'h0002_0001, 32'h0000_0704, 1'b0, 1'b1}));
    @(posedge clk);
    #1;
    z_fv = 1'b0;

    add_word(32'h0001_0001, 1'b0); add_word(32'h0000_0013, 1'b0);
    run_seg(32'h0000_0100, 1'b1);
    add_word(32'h0013_0001, 1'b0); add_word(32'h0001_0000, 1'b0);
    run_seg(32'h0000_0200, 1'b1);
    add_word(32'h0001_ffff, 1'b0);
    run_seg(32'h0000_0302, 1'b1);
    add_word(32'h0013_0001, 1'b0); add_word(32'h0001_0000, 1'b1);
    run_seg(32'h0000_0600, 1'b1);
    add_word(32'h1234_5677, 1'b0); add_word(32'h0001_0002, 1'b0); add_word(32'h0000_0013, 1'b0);
    run_seg(32'hffff_fffa, 1'b1);

    // Reset while a straddling instruction is being offered.
    add_word(32'h0013_0001, 1'b0);
    run_seg(32'h0000_0400, 1'b1);
    fv = 1'b1; fdata = 32'h0001_0000; faddr = 32'h0000_0404; ferr = 1'b0; iready = 1'b0;
    #1;
    chk("pre_reset_straddle", 80'({ivalid, instr, iaddr}),
        80'({1'b1, 32'h0000_0013, 32'h0000_0402}));
    #1;
    rst = 1'b1;
    #1;
    chk("mid_reset_out", 80'({ivalid, fready, instr, iaddr, irvc, ierr}), 80'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fv  = 1'b0;
    add_word(32'h0000_0013, 1'b0); add_word(32'h0002_0001, 1'b0);
    run_seg(32'h0000_0500, 1'b0);

    for (int s = 0; s < 25; s++) begin
      start = $urandom & 32'hffff_fffe;
      n = $urandom_range(8, 1);
      for (int k = 0; k < n; k++) begin
        hwa = $urandom;
        hwb = $urandom;
        if ($urandom_range(1) == 0) hwa[1:0] = 2'b11;
        if ($urandom_range(1) == 0) hwb[1:0] = 2'b11;
        add_word({hwb[15:0], hwa[15:0]}, $urandom_range(7) == 0);
      end
      run_seg(start, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvc_aligner.md
Name: rvc_aligner

Overview:
- Fetch-side producer of the instruction stream consumed by the compressed and full decoders.
- Accepts 32-bit word-aligned fetch words and emits one aligned instruction per handshake:
  - a 16-bit RVC instruction, zero-extended, with an RVC flag; or
  - a full 32-bit instruction, which may straddle two fetch words.
- A one-halfword carry buffer holds a leftover upper halfword between words.
- Handles redirects to odd-halfword targets.

Parameters:
- ADDR_W, 32, fetch/instruction address width in bits.
- RVC_EN, 1, 1 = C extension supported; 0 = every word passes through as one 32-bit instruction and the carry buffer is never used.

Ports:
- s_clk_i  in  1  clock.
- s_reset_i  in  1  reset. One clock; reset is asynchronous and active-high.
- s_flush_i  in  1  redirect; discard buffered state.
- s_flush_addr_i  in  ADDR_W  redirect target; only bit 1 is used.
- s_fetch_valid_i  in  1  fetch word valid.
- s_fetch_data_i  in  32  fetch word.
- s_fetch_addr_i  in  ADDR_W  word address of the fetch word; bits[1:0] = 0.
- s_fetch_err_i  in  1  bus error on the fetch word.
- s_fetch_ready_o  out  1  fetch word consumed this cycle.
- s_instr_valid_o  out  1  aligned instruction valid.
- s_instr_o  out  32  instruction; RVC instructions appear as {16'b0, hw}.
- s_instr_addr_o  out  ADDR_W  instruction address, halfword aligned.
- s_instr_rvc_o  out  1  instruction is 16-bit.
- s_instr_err_o  out  1  OR of the error flags of every word the instruction was taken from.
- s_instr_ready_i  in  1  decoder accepts the instruction.

Behaviour:
- State registers (all async-reset to 0):
  - hb[15:0], hb_addr[ADDR_W-1:1], hb_err
  - state ∈ {AL_EMPTY, AL_HALF}; reset value AL_EMPTY
  - skip (lower half of the next word is not on the path)
- A halfword is RVC iff bits[1:0] != 2'b11, and only when RVC_EN=1.
- Outputs are combinational from state and fetch inputs (zero latency).
  - Under reset: all outputs 0.
  - While s_flush_i=1: s_instr_valid_o=0 and s_fetch_ready_o=0.
- Handshake rules:
  - An instruction transfers on s_instr_valid_o & s_instr_ready_i.
  - A word is consumed on s_fetch_valid_i & s_fetch_ready_o.
  - s_fetch_ready_o never depends combinationally on s_fetch_valid_i.
  - Outputs are stable while valid and not accepted.
- AL_EMPTY, skip=0, word W at address A:
  - lo=W[15:0] is RVC: out lo at A, rvc=1. On accept: consume W, hb<=W[31:16], hb_addr<=A+2, hb_err<=err, go to AL_HALF.
  - lo is not RVC: out W at A, rvc=0. On accept: consume W, stay in AL_EMPTY.
- AL_EMPTY, skip=1:
  - hi=W[31:16] is RVC: out hi at A+2. On accept: consume W, skip<=0.
  - hi is not RVC: s_instr_valid_o=0, s_fetch_ready_o=1. On consume: hb<=hi, hb_addr<=A+2, skip<=0, go to AL_HALF.
- AL_HALF, hb is RVC:
  - Out hb at hb_addr, err=hb_err. Valid regardless of fetch valid.
  - s_fetch_ready_o=0. On accept: go to AL_EMPTY.
- AL_HALF, hb is the lower half of a 32-bit instruction:
  - Valid iff s_fetch_valid_i. Out {W[15:0], hb} at hb_addr, err=hb_err|s_fetch_err_i.
  - On accept: consume W, hb<=W[31:16], hb_addr<=A+2, hb_err<=s_fetch_err_i, stay in AL_HALF.
- Flush:
  - Next state AL_EMPTY; skip<=s_flush_addr_i[1] (forced 0 when RVC_EN=0).
  - Flush dominates any same-cycle handshake: no state update from the handshake.
- RVC_EN=0: every word is output as a 32-bit instruction; skip and hb remain 0.
- Reset mid-operation: buffer contents and skip are discarded immediately (async).
- Address arithmetic is modulo 2^ADDR_W; wrap from 0xFFFFFFFC to 0x0 requires no special handling.

Decomposition:
- Shared package p_hardisc gains:
  - enum al_state {AL_EMPTY, AL_HALF}
  - constant RVC_OPC_FULL = 2'b11
- One natural sub-module, al_halfbuf: hb, hb_addr and hb_err registers with load/clear controls.
- Decode of the RVC bits stays inline in rvc_aligner.

Test Plan:
- Words 0x00010001 @0x100, then 0x00000013 @0x104, ready=1 → out 0x0001 @0x100 rvc; 0x0001 @0x102 rvc (fetch_ready=0 that cycle); 0x00000013 @0x104 rvc=0.
- Straddle: 0x00130001 @0x200, then 0x00010000 @0x204 → 0x0001 @0x200 rvc; 0x00000013 @0x202 rvc=0; then 0x0001 @0x206 rvc.
- Flush to 0x302, word 0x0001FFFF @0x300 → lower half skipped; out 0x0001 @0x302 rvc; state AL_EMPTY.
- Backpressure: s_instr_ready_i=0 for 3 cycles in AL_HALF (32-bit case) → outputs stable, fetch_ready=0, no word consumed; accept on the 4th cycle.
- Error: straddle where the second word has s_fetch_err_i=1 → s_instr_err_o=1 on the straddling instruction and on the next instruction from that word's upper half.
- Flush asserted during an accepted handshake in AL_HALF, and reset asserted mid-straddle → valid=0, hb cleared, restart from the new address; RVC_EN=0 run passes 0x00010001 as a 32-bit instruction.
